// File: rtl/pwm_capture.sv
// pwm_capture: measures high time and period of an asynchronous PWM line.
// Reports the last complete period with a one-cycle `valid` strobe, flags a
// line that stops toggling (`stuck`), and optionally classifies the high
// time into a 2-bit band code when CODE_CLASSIFY_EN is defined.
module pwm_capture #(
  parameter int WIDTH       = 26,
  parameter int TIMEOUT     = 2000000,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwm_in,
  output logic [WIDTH-1:0] high_width,
  output logic [WIDTH-1:0] period,
  output logic             valid,
  output logic             stuck,
  output logic             stuck_level,
  output logic [1:0]       band
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HIGH = 2'd1;
  localparam logic [1:0] S_LOW  = 2'd2;

  localparam int              TW      = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]   TO_VAL  = TW'(TIMEOUT);
  localparam logic [TW-1:0]   TO_LAST = TW'(TIMEOUT - 1);
  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  logic [SYNC_STAGES-1:0] sync_ff;
  logic                   level;
  logic                   level_prev;
  logic                   rise_q;
  logic                   fall_q;
  logic [1:0]             state;
  logic [WIDTH-1:0]       hcnt;
  logic [WIDTH-1:0]       pcnt;
  logic [TW-1:0]          idle_cnt;
  logic                   edge_seen;
  logic                   timeout_hit;
  logic                   capture;

  // Counters stop at all-ones so a very long pulse reads as "at least max".
  function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  // Synchronizer, registered level copy and registered edge pulses.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours; blocking here would collapse the chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_ff    <= '0;
      level      <= 1'b0;
      level_prev <= 1'b0;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
    end else begin
      sync_ff    <= {sync_ff[SYNC_STAGES-2:0], pwm_in};
      level      <= sync_ff[SYNC_STAGES-1];
      level_prev <= level;
      rise_q     <= level & ~level_prev;
      fall_q     <= ~level & level_prev;
    end
  end

  assign edge_seen   = rise_q | fall_q;
  // An edge in the same cycle always wins over the timeout.
  assign timeout_hit = !edge_seen && (idle_cnt == TO_LAST);
  assign capture     = (state == S_LOW) && rise_q;

  // Cycles since the last edge; parks at TIMEOUT so the timeout fires once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt <= '0;
    end else if (edge_seen) begin
      idle_cnt <= '0;
    end else if (idle_cnt != TO_VAL) begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end

  // Measurement FSM: IDLE arms on a rise, HIGH/LOW count, LOW->rise publishes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      hcnt        <= '0;
      pcnt        <= '0;
      high_width  <= '0;
      period      <= '0;
      valid       <= 1'b0;
      stuck       <= 1'b0;
      stuck_level <= 1'b0;
    end else begin
      // NOTE: default-assigning the strobe here makes it a single-cycle pulse
      // without listing it in every branch below.
      valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (rise_q) begin
            state <= S_HIGH;
            hcnt  <= WIDTH'(1);
            pcnt  <= WIDTH'(1);
            stuck <= 1'b0;
          end else if (timeout_hit) begin
            stuck       <= 1'b1;
            stuck_level <= level;
          end
        end
        S_HIGH: begin
          if (timeout_hit) begin
            stuck       <= 1'b1;
            stuck_level <= level;
            state       <= S_IDLE;
          end else begin
            pcnt <= sat_inc(pcnt);
            if (fall_q) state <= S_LOW;
            else        hcnt  <= sat_inc(hcnt);
          end
        end
        S_LOW: begin
          if (rise_q) begin
            high_width <= hcnt;
            period     <= pcnt;
            valid      <= 1'b1;
            hcnt       <= WIDTH'(1);
            pcnt       <= WIDTH'(1);
            state      <= S_HIGH;
          end else if (timeout_hit) begin
            stuck       <= 1'b1;
            stuck_level <= level;
            state       <= S_IDLE;
          end else begin
            pcnt <= sat_inc(pcnt);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef CODE_CLASSIFY_EN
  // Band code registered alongside valid from the high time being published.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      band <= 2'b00;
    end else if (capture) begin
      if (32'(hcnt) < 32'd62500)       band <= 2'b00;
      else if (32'(hcnt) < 32'd86250)  band <= 2'b01;
      else if (32'(hcnt) < 32'd122500) band <= 2'b10;
      else                             band <= 2'b11;
    end
  end
`else
  assign band = 2'b00;
`endif

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: directed and random pulse trains on pwm_in, checked against
// an edge-time model of the line (high time = fall - rise, period = rise - rise).
module tb_pwm_capture;

  localparam int W    = 8;
  localparam int TO   = 400;
  localparam int SS   = 2;
  localparam int MAXV = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         pwm_in;
  logic [W-1:0] high_width;
  logic [W-1:0] period;
  logic         valid;
  logic         stuck;
  logic         stuck_level;
  logic [1:0]   band;

  pwm_capture #(.WIDTH(W), .TIMEOUT(TO), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst(rst), .pwm_in(pwm_in),
    .high_width(high_width), .period(period), .valid(valid),
    .stuck(stuck), .stuck_level(stuck_level), .band(band)
  );

  always #5 clk = ~clk;

  typedef struct {
    int hw;
    int per;
    int bnd;
    int cyc;
  } strobe_t;

  strobe_t obs_q[$];
  strobe_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model state: edge times of the driven line.
  bit cur, armed, have_fall, m_stuck, m_stuck_lvl;
  int rise_t, fall_t, last_hw, last_per;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every strobe together with the cycle it was seen.
  always @(negedge clk) begin
    if (valid === 1'b1) obs_q.push_back('{int'(high_width), int'(period), int'(band), cyc});
  end

  function automatic int band_of(input int hw);
`ifdef CODE_CLASSIFY_EN
    if (hw < 62500)  return 0;
    if (hw < 86250)  return 1;
    if (hw < 122500) return 2;
    return 3;
`else
    return 0;
`endif
  endfunction

  function automatic int sat(input int v);
    return (v > MAXV) ? MAXV : v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    cur = 0; armed = 0; have_fall = 0; m_stuck = 0; m_stuck_lvl = 0;
    last_hw = 0; last_per = 0;
    pwm_in = 1'b0;
  endtask

  // Drive the line to lvl for n cycles and update the model's expectations.
  task automatic seg(input bit lvl, input int n);
    int hw;
    if (lvl && !cur) begin
      if (armed && have_fall) begin
        hw = sat(fall_t - rise_t);
        exp_q.push_back('{hw, sat(cyc - rise_t), band_of(hw), 0});
      end
      armed = 1; have_fall = 0; rise_t = cyc; m_stuck = 0;
    end else if (!lvl && cur && armed) begin
      fall_t = cyc; have_fall = 1;
    end
    cur    = lvl;
    pwm_in = lvl;
    if (n > TO) begin
      armed = 0; m_stuck = 1; m_stuck_lvl = lvl;
    end
    repeat (n) @(negedge clk);
  endtask

  // Let the pipeline drain, then compare observed strobes with the model.
  task automatic settle_and_check(input string tag);
    strobe_t o, e;
    repeat (10) @(negedge clk);
    chk({tag, " strobes"}, obs_q.size(), exp_q.size());
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      chk({tag, " high_width"}, o.hw, e.hw);
      chk({tag, " period"}, o.per, e.per);
      chk({tag, " band"}, o.bnd, e.bnd);
      last_hw = e.hw; last_per = e.per;
    end
    obs_q.delete();
    exp_q.delete();
    chk({tag, " hold high_width"}, high_width, last_hw);
    chk({tag, " hold period"}, period, last_per);
    chk({tag, " stuck"}, stuck, m_stuck);
  endtask

  initial begin
    int r2;
    rst = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset high_width", high_width, 0);
    chk("reset period", period, 0);
    chk("reset valid", valid, 0);
    chk("reset stuck", stuck, 0);
    chk("reset stuck_level", stuck_level, 0);
    chk("reset band", band, 0);

    // Line never toggles after reset: stuck exactly TIMEOUT cycles later.
    rst = 1'b0;
    repeat (TO - 1) @(negedge clk);
    chk("idle stuck early", stuck, 0);
    @(negedge clk);
    chk("idle stuck", stuck, 1);
    chk("idle stuck_level", stuck_level, 0);
    repeat (100) @(negedge clk);
    chk("idle no valid", obs_q.size(), 0);
    m_stuck = 1;

    // Fixed train; second rise sets the latency reference.
    seg(1, 20); seg(0, 30);
    r2 = cyc;
    seg(1, 20); seg(0, 30);
    seg(1, 20); seg(0, 30);
    seg(1, 20);
    repeat (10) @(negedge clk);
    chk("latency", (obs_q.size() > 0) ? obs_q[0].cyc - r2 : -1, SS + 3);
    settle_and_check("fixed");

    // Step in high time at constant period.
    seg(0, 20); seg(1, 40); seg(0, 20); seg(1, 40); seg(0, 20);
    seg(1, 25); seg(0, 35); seg(1, 25); seg(0, 35); seg(1, 1);
    settle_and_check("step");

    // Minimum pulses: 1 high, 2 low.
    for (int i = 0; i < 5; i++) begin
      seg(0, 2); seg(1, 1);
    end
    settle_and_check("min");

    // Random train.
    for (int i = 0; i < 8; i++) begin
      seg(0, int'($urandom_range(60, 1)));
      seg(1, int'($urandom_range(60, 1)));
    end
    settle_and_check("rand");

    // Counters saturate at all-ones.
    seg(0, 50); seg(1, 300); seg(0, 50); seg(1, 5);
    settle_and_check("sat");

    // Reset in the middle of a high phase.
    seg(0, 20); seg(1, 30);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("midrst high_width", high_width, 0);
    chk("midrst period", period, 0);
    chk("midrst valid", valid, 0);
    chk("midrst band", band, 0);
    chk("midrst stuck", stuck, 0);
    model_reset();
    obs_q.delete();
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    seg(0, 10);
    for (int i = 0; i < 2; i++) begin
      seg(1, 30); seg(0, 40);
    end
    seg(1, 30);
    settle_and_check("rst");

    // Line held high past the timeout, then resumes toggling.
    seg(0, 20); seg(1, 500);
    settle_and_check("stuck high");
    chk("stuck_level", stuck_level, 1);
    seg(0, 20);
    chk("stuck held", stuck, 1);
    seg(1, 20);
    chk("stuck cleared", stuck, 0);
    seg(0, 30); seg(1, 20);
    settle_and_check("resume");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
- Measures an incoming servo-style PWM signal: high time, period, and (optionally) a 2-bit band code.
- This is the receive-side counterpart to the duty-cycle PWM generators. It lets feedback PWM, or a loop-back of the `out[*]` lines, be checked and reported back to the Pi or the LED logic.
- One instance per monitored line.

Parameters:
- WIDTH, 26, width of all cycle counters and measured outputs.
- TIMEOUT, 2000000, clk cycles without an edge before the line is declared stuck.
- SYNC_STAGES, 2, number of flip-flops in the input synchronizer (minimum 2).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- pwm_in  input  1  asynchronous PWM line to measure.
- high_width  output  WIDTH  high time of the last complete period, in clk cycles.
- period  output  WIDTH  last complete period (rising edge to rising edge), in clk cycles.
- valid  output  1  one-cycle strobe; `high_width` and `period` were just updated.
- stuck  output  1  level; no edge seen for TIMEOUT cycles.
- stuck_level  output  1  synchronized `pwm_in` level captured when `stuck` was set.
- band  output  2  width band code (only with CODE_CLASSIFY_EN, else tied 0).

Behaviour:
- Reset values: `high_width`=0, `period`=0, `valid`=0, `stuck`=0, `stuck_level`=0, `band`=0, state=IDLE, all counters=0, synchronizer flops=0.
- Input path: SYNC_STAGES-flop synchronizer, then one registered copy. `rise` = sync & ~prev; `fall` = ~sync & prev.
- States:
  - IDLE: wait for `rise`, then go to HIGH. `hcnt` is loaded with 1 and `pcnt` with 1. No output update.
  - HIGH: increment `hcnt` and `pcnt` each cycle. On `fall`, go to LOW; `pcnt` still increments.
  - LOW: increment `pcnt`. On `rise`, register `high_width`=`hcnt` and `period`=`pcnt`, pulse `valid` for 1 cycle, reload `hcnt`=1 and `pcnt`=1, go to HIGH.
- Exactness: a pulse high for N clk cycles and low for M cycles (as seen after the synchronizer) reports `high_width`=N and `period`=N+M.
- First partial period after reset or after IDLE is discarded. The first `valid` comes only after one full rise-fall-rise sequence.
- Latency: `valid` is high in the cycle starting SYNC_STAGES+2 clk edges after the edge that first samples `pwm_in` high.
- Outputs hold their values between `valid` strobes.
- Saturation: `hcnt` and `pcnt` stop at 2^WIDTH-1 and never wrap.
- Timeout:
  - An idle counter resets on any `rise` or `fall` and increments otherwise.
  - When it reaches TIMEOUT while in HIGH or LOW: set `stuck`=1, latch `stuck_level`, go to IDLE. `high_width` and `period` are unchanged and no `valid` is issued.
  - In IDLE the counter also runs, so a line that never toggles after reset raises `stuck`.
  - `stuck` clears on the next `rise`.
- Simultaneous events: a `rise` in the same cycle the timeout would fire takes priority; no stuck is flagged.
- Reset asserted mid-measurement: immediate return to reset values; the partial period is lost.

Optional Feature:
- Macro CODE_CLASSIFY_EN.
- Defined: `band` is registered together with `valid` from the new `high_width`:
  - below 62500 gives 2'b00 (nominal 50000)
  - below 86250 gives 2'b01 (nominal 75000)
  - below 122500 gives 2'b10 (nominal 97500/100000)
  - otherwise 2'b11 (nominal 145000)
  - `band` resets to 0 and holds between strobes.
- Not defined: no comparators are built; `band` is constant 2'b00.

Test Plan:
- Reset, then `pwm_in` low for 3000000 cycles -> `stuck`=1 at cycle TIMEOUT after reset release (+ sync), `stuck_level`=0, `valid` never pulses.
- Drive 3 periods of 50000 high / 950000 low -> first `valid` after the second rising edge; `high_width`=50000, `period`=1000000 on every strobe. With CODE_CLASSIFY_EN, `band`=2'b00.
- Step from 145000 high to 97500 high (period 1000000) -> next strobe gives `high_width`=97500 and `band`=2'b10; the strobe before gives 145000 and 2'b11.
- Pulse 1 cycle high / 2 cycles low repeatedly -> `high_width`=1, `period`=3 every strobe.
- Assert `rst` during a HIGH phase, release, resume 75000/925000 -> outputs 0 after reset. The first strobe appears only after a full new period: `high_width`=75000, `band`=2'b01.
- Hold `pwm_in` high past TIMEOUT, then toggle normally -> `stuck`=1 with `stuck_level`=1. It clears on the next rising edge, and `valid` resumes one full period later.
